exp09_env_uart: RTL and testbench
=================================

# exp09_env_uart

Self-contained serial loopback environment. It pairs a UART-style transmitter and receiver on one clock, drives the transmitter's serial line out on `sq_pin`, and feeds that same line internally back into the receiver. The block is the top of the exp09 experiment and is exercised by a bench that sends a byte and waits for it to come back on the receive side.

## Interface
Parameters:
- `CLK_HZ`, default 20_000_000: system clock frequency.
- `BAUD`, default 9600: serial bit rate.
- `BIT_CLKS`, default CLK_HZ/BAUD (integer division, 2083): clocks per bit. This is a derived localparam.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `tx_en_sig`, input, 1: level request to transmit `tx_data`.
- `tx_data`, input, 8: byte to send. It is latched when the frame starts.
- `tx_done`, output, 1: one-cycle pulse at the end of the transmitted frame.
- `rx_en_sig`, input, 1: level enable for the receiver.
- `rx_done`, output, 1: one-cycle pulse when a valid byte is received.
- `rx_data`, output, 8: last received byte. It holds until the next valid frame.
- `sq_pin`, output, 1: serial line. It idles high and is internally looped to the receiver input.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, optional parity bit (see Configuration), 1 stop bit (1).
- TX FSM states: IDLE → START → DATA(0..7) → [PARITY] → STOP → DONE → GUARD → IDLE.
  - IDLE: `sq_pin`=1. If `tx_en_sig` is sampled 1, latch `tx_data` and go to START.
  - Each of START, DATA, PARITY and STOP drives its bit level for exactly BIT_CLKS cycles.
  - DONE: `tx_done`=1 for one cycle.
  - GUARD: one cycle in which `tx_en_sig` is ignored. This lets the requester drop the enable after seeing `tx_done`.
  - If `tx_en_sig` is still 1 in IDLE after GUARD, a new frame starts.
- RX path:
  - The loopback line passes through a 2-flop synchronizer.
  - States: IDLE → START → DATA → [PARITY] → STOP → DONE → GUARD.
  - IDLE, when `rx_en_sig`=1: detect a falling edge and move to START.
  - START: wait BIT_CLKS/2 and re-sample. If the line is high, treat it as a glitch and return to IDLE.
  - Data bits are then sampled every BIT_CLKS cycles, at mid-bit.
  - Stop bit sampled 1 (and parity good, if enabled): update `rx_data` and pulse `rx_done` for one cycle.
  - Stop bit sampled 0, or parity bad: framing error. Discard the byte, no `rx_done`, go to IDLE.
- While `rx_en_sig`=0 the receiver stays in IDLE and ignores the line. Deasserting it mid-frame aborts the frame at the next clock, with no `rx_done`.
- TX runs independently of `rx_en_sig`.
- Deasserting `tx_en_sig` mid-frame does not abort it; the frame completes.

## Timing
- Reset values: `sq_pin`=1, `tx_done`=0, `rx_done`=0, `rx_data`=8'h00. Both FSMs are in IDLE and all counters are 0.
- Reset asserted mid-frame: everything returns to the reset values immediately (asynchronous).
- Start of frame: the start bit appears on `sq_pin` in the cycle after `tx_en_sig` is sampled 1 in IDLE.
- Frame length: 10·BIT_CLKS cycles (11·BIT_CLKS with parity), then `tx_done` in the next cycle.
- Receive latency: `rx_done` rises about 2 (synchronizer) + 9.5·BIT_CLKS (10.5·BIT_CLKS with parity) + 1 cycles after the start-bit edge on `sq_pin`. It therefore precedes `tx_done` by about half a bit.
- Simultaneous events: if `tx_en_sig`=1 during DONE or GUARD, no new frame starts until IDLE.

## Configuration
- `EXP09_PARITY_EN`:
  - Defined: an even-parity bit is inserted after D7. The receiver checks it, and on mismatch discards the frame with no `rx_done`.
  - Undefined: 8N1 with no parity logic.

## Structure
- Shared package `exp09_pkg`:
  - CLK_HZ/BAUD defaults.
  - TX/RX state enum typedefs.
  - Frame bit-count constants (8 data bits, total bits with and without parity).
- Sub-module `exp09_baud_tick`: a BIT_CLKS counter with a mid-bit tick option and clear input. It is instantiated once in TX and once in RX.
- TX and RX FSMs live in the top.

## Test plan
- Reset: hold `rst_n`=0 for 1000 ns → `sq_pin`=1, `tx_done`=0, `rx_done`=0, `rx_data`=00.
- Loopback 0x55:
  - Stimulus: `rx_en_sig`=1; set `tx_data`=8'h55 and `tx_en_sig`=1 until `tx_done`.
  - Response: `sq_pin` shows 0,1,0,1,0,1,0,1,0,1 with BIT_CLKS per bit, `rx_done` pulses once with `rx_data`=55, and `tx_done` pulses once.
- Bytes 0x00, 0xFF, 0xA3 back-to-back with `tx_en_sig` held high → three frames, each with one GUARD cycle, and `rx_data` matching each byte in order.
- `rx_en_sig`=0 while sending 0x3C → no `rx_done` and `rx_data` unchanged. Then `tx_done` still pulses.
- Async reset at D4 of a frame → `sq_pin`=1 at once and no done pulses. A subsequent frame works.
- With `EXP09_PARITY_EN`:
  - Send 0x07 → parity bit =1 and `rx_done` pulses with `rx_data`=07.
  - Force the parity bit low on the loopback → no `rx_done`.

Source files
------------

// File: rtl/exp09_pkg.sv
// exp09_pkg: shared defaults, FSM state types and frame constants for the exp09 UART loopback
package exp09_pkg;

   localparam int CLK_HZ_DEF     = 20_000_000;
   localparam int BAUD_DEF       = 9600;
   localparam int DATA_BITS      = 8;
   localparam int FRAME_BITS_8N1 = 10;
   localparam int FRAME_BITS_8E1 = 11;

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_DONE, TX_GUARD
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_DONE, RX_GUARD
   } rx_state_t;

   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic even_par(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/exp09_baud_tick.sv
// exp09_baud_tick: bit-period counter with a half-period (mid-bit) tick option and synchronous clear
module exp09_baud_tick #(
   parameter int BIT_CLKS = 2083
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_half,
   output logic o_tick
);

   localparam int CW = $clog2(BIT_CLKS + 1);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_last;

   assign w_last = i_half ? CW'(BIT_CLKS / 2 - 1) : CW'(BIT_CLKS - 1);
   assign o_tick = !i_clr && (r_cnt == w_last);

   // Count cycles within the current period; wrap on tick so the next period starts at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_clr || o_tick)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/exp09_env_uart.sv
// exp09_env_uart: UART transmitter looped back into a receiver on one clock.
// Optional even parity bit after D7 when EXP09_PARITY_EN is defined (default build is 8N1).
module exp09_env_uart
   import exp09_pkg::*;
#(
   parameter int CLK_HZ = CLK_HZ_DEF,
   parameter int BAUD   = BAUD_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_en_sig,
   input  logic [7:0] tx_data,
   output logic       tx_done,
   input  logic       rx_en_sig,
   output logic       rx_done,
   output logic [7:0] rx_data,
   output logic       sq_pin
);

   localparam int BIT_CLKS = CLK_HZ / BAUD;

   tx_state_t  r_tx_st;
   logic [7:0] r_tx_sh;
   logic [2:0] r_tx_bit;
   logic       r_sq;
   logic       r_tx_done;
`ifdef EXP09_PARITY_EN
   logic       r_tx_par;
   logic       r_rx_par;
`endif

   rx_state_t  r_rx_st;
   logic [7:0] r_rx_sh;
   logic [2:0] r_rx_bit;
   logic [7:0] r_rx_data;
   logic       r_rx_done;
   logic       r_s1;
   logic       r_s2;
   logic       r_prev;

   logic       w_line;
   logic       w_tx_tick;
   logic       w_tx_clr;
   logic       w_rx_tick;
   logic       w_rx_clr;
   logic       w_rx_half;

   assign w_line  = r_sq;
   assign sq_pin  = r_sq;
   assign tx_done = r_tx_done;
   assign rx_done = r_rx_done;
   assign rx_data = r_rx_data;

   assign w_tx_clr  = (r_tx_st == TX_IDLE) || (r_tx_st == TX_DONE) || (r_tx_st == TX_GUARD);
   assign w_rx_clr  = !rx_en_sig || (r_rx_st == RX_IDLE) || (r_rx_st == RX_DONE) || (r_rx_st == RX_GUARD);
   assign w_rx_half = (r_rx_st == RX_START);

   exp09_baud_tick #(.BIT_CLKS(BIT_CLKS)) u_tx_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_tx_clr),
      .i_half (1'b0),
      .o_tick (w_tx_tick)
   );

   exp09_baud_tick #(.BIT_CLKS(BIT_CLKS)) u_rx_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_rx_clr),
      .i_half (w_rx_half),
      .o_tick (w_rx_tick)
   );

   // TX FSM: registered line level, each bit held for one full bit period, then DONE and one GUARD cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_st   <= TX_IDLE;
         r_tx_sh   <= '0;
         r_tx_bit  <= '0;
         r_sq      <= 1'b1;
         r_tx_done <= 1'b0;
`ifdef EXP09_PARITY_EN
         r_tx_par  <= 1'b0;
`endif
      end else begin
         case (r_tx_st)
            TX_IDLE: if (tx_en_sig) begin
               r_tx_sh  <= tx_data;
               r_tx_bit <= '0;
               r_sq     <= 1'b0;
               r_tx_st  <= TX_START;
`ifdef EXP09_PARITY_EN
               r_tx_par <= even_par(tx_data);
`endif
            end
            TX_START: if (w_tx_tick) begin
               r_sq    <= r_tx_sh[0];
               r_tx_sh <= {1'b0, r_tx_sh[7:1]};
               r_tx_st <= TX_DATA;
            end
            TX_DATA: if (w_tx_tick) begin
               if (r_tx_bit == 3'd7) begin
`ifdef EXP09_PARITY_EN
                  r_sq    <= r_tx_par;
                  r_tx_st <= TX_PARITY;
`else
                  r_sq    <= 1'b1;
                  r_tx_st <= TX_STOP;
`endif
               end else begin
                  r_sq     <= r_tx_sh[0];
                  r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
                  r_tx_bit <= r_tx_bit + 1'b1;
               end
            end
            TX_PARITY: if (w_tx_tick) begin
               r_sq    <= 1'b1;
               r_tx_st <= TX_STOP;
            end
            TX_STOP: if (w_tx_tick) begin
               r_tx_done <= 1'b1;
               r_tx_st   <= TX_DONE;
            end
            TX_DONE: begin
               r_tx_done <= 1'b0;
               r_tx_st   <= TX_GUARD;
            end
            default: begin
               r_tx_done <= 1'b0;
               r_tx_st   <= TX_IDLE;
            end
         endcase
      end
   end

   // Two-flop synchronizer on the looped-back line plus a delayed copy for falling-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1   <= 1'b1;
         r_s2   <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_s1   <= w_line;
         r_s2   <= r_s1;
         r_prev <= r_s2;
      end
   end

   // RX FSM: confirm the start bit at half a period, then sample each later bit at mid-bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_st   <= RX_IDLE;
         r_rx_sh   <= '0;
         r_rx_bit  <= '0;
         r_rx_data <= '0;
         r_rx_done <= 1'b0;
`ifdef EXP09_PARITY_EN
         r_rx_par  <= 1'b0;
`endif
      end else if (!rx_en_sig) begin
         r_rx_st   <= RX_IDLE;
         r_rx_done <= 1'b0;
      end else begin
         case (r_rx_st)
            RX_IDLE: if (r_prev && !r_s2) r_rx_st <= RX_START;
            RX_START: if (w_rx_tick) begin
               r_rx_bit <= '0;
               r_rx_st  <= r_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (w_rx_tick) begin
               r_rx_sh <= {r_s2, r_rx_sh[7:1]};
               r_rx_bit <= r_rx_bit + 1'b1;
`ifdef EXP09_PARITY_EN
               if (r_rx_bit == 3'd7) r_rx_st <= RX_PARITY;
`else
               if (r_rx_bit == 3'd7) r_rx_st <= RX_STOP;
`endif
            end
            RX_PARITY: if (w_rx_tick) begin
`ifdef EXP09_PARITY_EN
               r_rx_par <= r_s2;
`endif
               r_rx_st  <= RX_STOP;
            end
            RX_STOP: if (w_rx_tick) begin
`ifdef EXP09_PARITY_EN
               if (r_s2 && (r_rx_par == even_par(r_rx_sh))) begin
`else
               if (r_s2) begin
`endif
                  r_rx_data <= r_rx_sh;
                  r_rx_done <= 1'b1;
                  r_rx_st   <= RX_DONE;
               end else begin
                  r_rx_st   <= RX_IDLE;
               end
            end
            RX_DONE: begin
               r_rx_done <= 1'b0;
               r_rx_st   <= RX_GUARD;
            end
            default: begin
               r_rx_done <= 1'b0;
               r_rx_st   <= RX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exp09_env_uart.sv
// tb_exp09_env_uart: table-driven loopback bench with an rx scoreboard queue
module tb_exp09_env_uart;

   localparam int B = 16;
`ifdef EXP09_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   typedef struct {
      logic [7:0] d;
      logic       en;
      logic       last;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_en_sig = 1'b0;
   logic       rx_en_sig = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_done;
   logic       rx_done;
   logic [7:0] rx_data;
   logic       sq_pin;

   int         errs = 0;
   int         checks = 0;
   logic [7:0] q[$];
   logic [7:0] exp_rx = 8'h00;
   logic [7:0] m_exp;
   vec_t       v[6];

   exp09_env_uart #(.CLK_HZ(1_600_000), .BAUD(100_000)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_en_sig (tx_en_sig),
      .tx_data   (tx_data),
      .tx_done   (tx_done),
      .rx_en_sig (rx_en_sig),
      .rx_done   (rx_done),
      .rx_data   (rx_data),
      .sq_pin    (sq_pin)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic logic exp_bit(input logic [7:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (k == FB - 1) return 1'b1;
      return ^d;
   endfunction

   // Scoreboard: every rx_done pops the oldest expected byte.
   always @(negedge clk) begin
      if (rst_n && rx_done) begin
         checks++;
         if (q.size() == 0) begin
            errs++;
            $display("FAIL rx_unexpected: got rx_done with %0h, want none", rx_data);
         end else begin
            m_exp = q.pop_front();
            if (rx_data !== m_exp) begin
               errs++;
               $display("FAIL rx_data_sb: got %0h, want %0h", rx_data, m_exp);
            end
         end
      end
   end

   // Entered at a negedge with the TX FSM in IDLE; returns at the IDLE negedge after GUARD.
   task automatic frame(input logic [7:0] d, input logic en, input logic last);
      tx_data = d;
      rx_en_sig = en;
      tx_en_sig = 1'b1;
      if (en) begin
         q.push_back(d);
         exp_rx = d;
      end
      chk("idle_sq", sq_pin, 1);
      for (int n = 1; n <= FB * B + 1; n++) begin
         @(negedge clk);
         if (n % B == B / 2)
            chk($sformatf("bit%0d_of_%02h", (n - 1) / B, d), sq_pin, exp_bit(d, (n - 1) / B));
         if (n == FB * B) chk("tx_done_early", tx_done, 0);
         if (n == FB * B + 1) begin
            chk($sformatf("tx_done_%02h", d), tx_done, 1);
            if (last) tx_en_sig = 1'b0;
         end
      end
      @(negedge clk);
      chk("guard_sq", sq_pin, 1);
      chk("guard_no_done", tx_done, 0);
      @(negedge clk);
      chk($sformatf("rx_data_after_%02h", d), rx_data, exp_rx);
   endtask

   initial begin
      v[0] = '{8'h55, 1'b1, 1'b1};
      v[1] = '{8'h00, 1'b1, 1'b0};
      v[2] = '{8'hFF, 1'b1, 1'b0};
      v[3] = '{8'hA3, 1'b1, 1'b1};
      v[4] = '{8'h3C, 1'b0, 1'b1};
      v[5] = '{8'hA5, 1'b1, 1'b1};

      #1000;
      chk("rst_sq", sq_pin, 1);
      chk("rst_tx_done", tx_done, 0);
      chk("rst_rx_done", rx_done, 0);
      chk("rst_rx_data", rx_data, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) frame(v[i].d, v[i].en, v[i].last);

      tx_data = 8'h0F;
      rx_en_sig = 1'b1;
      tx_en_sig = 1'b1;
      repeat (5 * B + B / 2) @(negedge clk);
      chk("d4_level", sq_pin, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_sq", sq_pin, 1);
      chk("async_rst_tx_done", tx_done, 0);
      chk("async_rst_rx_data", rx_data, 8'h00);
      tx_en_sig = 1'b0;
      exp_rx = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (FB * B + 20) begin
         @(negedge clk);
         if (tx_done) chk("tx_done_after_rst", tx_done, 0);
      end
      chk("line_idle_after_rst", sq_pin, 1);

      frame(v[5].d, v[5].en, v[5].last);

      chk("scoreboard_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
